mxv_mac_feeder: RTL and testbench
=================================

Name: mxv_mac_feeder

Overview:
- Initiator/driver for the streaming MAC datapath (mac_nnbit_1cc). It sequences an M x K matrix-vector product through the MAC one element pair per cycle.
- Accepts element pairs (G[m][k], E[k]) on a valid/ready input stream. Pulses the MAC clear between rows and waits out MAC latency.
- Captures each row's accumulated dot product and emits it on a valid/ready result stream.
- Sits between the operand source (memory/garbled-input loader) and the result consumer, replacing the hand-written bench driver.

Parameters:
- N, 8, signed operand bit-width
- K, 3, vector dimension (elements per row), >=1
- M, 3, number of matrix rows per job, >=1
- MAC_LAT, 1, cycles from mac_g/mac_e presentation until mac_o includes that product, >=1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid && in_ready
- in_g  in  N  signed G[m][k]
- in_e  in  N  signed E[k]
- mac_clr  out  1  synchronous clear to MAC accumulator (drives MAC rst), one-cycle pulse
- mac_g  out  N  registered operand to MAC
- mac_e  out  N  registered operand to MAC
- mac_o  in  2N+K-1  signed MAC accumulator output
- res_valid  out  1  row result valid
- res_ready  in  1  consumer ready
- res_data  out  2N+K-1  signed row dot product
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last row's result handshake

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: in_ready, mac_clr, mac_g, mac_e, res_valid, res_data, busy, done. Row counter r and element counter k cleared. Reset mid-job abandons the job; no partial result emitted.
- FSM states: IDLE, CLR, FEED, DRAIN, HOLD.
- IDLE: start=1 -> CLR, r=0.
- CLR: one cycle, mac_clr=1, mac_g=mac_e=0, k=0 -> FEED.
- FEED: in_ready=1 (combinational from state).
  - On handshake: mac_g<=in_g, mac_e<=in_e, k++.
  - On cycles without handshake: mac_g<=0, mac_e<=0, so the MAC accumulates zero (bubble-safe).
  - Handshake with k==K-1 -> DRAIN, drain counter d=MAC_LAT.
- DRAIN: mac_g=mac_e=0, d decrements each cycle. Leaves when d reaches 0, i.e. after MAC_LAT+1 cycles, once the last product is in mac_o.
  - Exit: res_data<=mac_o, res_valid<=1 -> HOLD.
- HOLD: res_data stable, res_valid=1 until res_ready=1.
  - On handshake: res_valid<=0.
  - If r==M-1: done<=1 (one cycle), go IDLE.
  - Else: r++, go CLR.
- Widths: MAC sum of K signed N x N products fits 2N+K-1 bits, so no overflow by construction. res_data is a straight capture, no re-extension.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid outside FEED is not accepted.
  - K=1: FEED lasts exactly one handshake.
  - res_ready held high: HOLD lasts one cycle.
  - start coincident with reset release is ignored (reset wins).
- Minimum job latency, start to done with no stalls: M*(1+K+MAC_LAT+1+1) cycles.

Optional Feature:
- Macro MXV_ROWIDX_EN.
- Defined: adds output port res_row, width $clog2(M) (min 1), equal to r while res_valid=1, 0 otherwise and at reset.
- Undefined: port absent, behaviour otherwise identical.

Decomposition:
- Package mxv_pkg: FSM state enum (IDLE, CLR, FEED, DRAIN, HOLD); localparam function for result width 2N+K-1; row-index width helper.
- Single flat module; no sub-module needed.
- Bench instantiates mac_nnbit_1cc as the MAC, with mac_clr wired to its rst.

Test Plan:
- Nominal job, G={{29,74,-39},{67,-71,56},{75,-45,34}}, E={-38,-91,47} streamed back-to-back, res_ready=1 -> res_data -9669, 6547, 2843 in order; done pulses once; busy falls with done.
- Same job with in_valid deasserted 2 cycles between each pair -> identical results; mac_g=mac_e=0 during bubbles.
- Same job with res_ready low 5 cycles at each result -> res_data stable and res_valid held; no extra in_ready until handshake.
- rst_n pulsed low during row 1 FEED -> all outputs 0 immediately. A new start with row-0 operands {1,1,1},{2,3,4} (K=3, M=1 run) -> 9.
- start pulsed while busy and in_valid driven in HOLD -> both ignored; results match nominal.
- With MXV_ROWIDX_EN defined -> res_row 0, 1, 2 accompany the three nominal results.

Source files
------------

// File: rtl/mxv_mac_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mxv_pkg : shared types and width helpers for the mxv_mac_feeder slice.
//
// Contents
//   state_t  - feeder FSM states (IDLE, CLR, FEED, DRAIN, HOLD)
//   res_w    - accumulator / result width for K signed N x N products
//   idx_w    - index width for a counter over v values (never below 1 bit)
//
// Optional build macro used elsewhere in the slice: MXV_ROWIDX_EN
// ---------------------------------------------------------------------------
package mxv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // A sum of k signed n x n products needs 2n bits plus log2(k) growth;
  // k-1 extra bits is a safe closed form for the MAC this block drives.
  function automatic int res_w(input int n, input int k);
    return 2 * n + k - 1;
  endfunction

  function automatic int idx_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mxv_mac_feeder_if.sv
// ---------------------------------------------------------------------------
// mxv_mac_feeder_if : operand and result streams of the matrix-vector feeder.
//
// Signals
//   in_valid / in_ready / in_g / in_e   operand pair stream (G[m][k], E[k])
//   res_valid / res_ready / res_data    per-row dot product stream
//   res_row                             row index of res_data (MXV_ROWIDX_EN)
//
// Modports
//   slave  - the feeder (consumes operands, produces results)
//   master - operand source + result consumer
//
// Build macro: MXV_ROWIDX_EN adds res_row and the M parameter.
// ---------------------------------------------------------------------------
interface mxv_mac_feeder_if
  import mxv_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 3
`ifdef MXV_ROWIDX_EN
  ,
  parameter int M = 3
`endif
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic signed [N-1:0]       in_g;
  logic signed [N-1:0]       in_e;

  logic                      res_valid;
  logic                      res_ready;
  logic signed [res_w(N,K)-1:0] res_data;
`ifdef MXV_ROWIDX_EN
  logic [idx_w(M)-1:0]       res_row;
`endif

  modport slave (
    input  in_valid, in_g, in_e, res_ready,
    output in_ready, res_valid, res_data
`ifdef MXV_ROWIDX_EN
    , output res_row
`endif
  );

  modport master (
    output in_valid, in_g, in_e, res_ready,
    input  in_ready, res_valid, res_data
`ifdef MXV_ROWIDX_EN
    , input res_row
`endif
  );

endinterface

// File: rtl/mxv_mac_feeder.sv
// ---------------------------------------------------------------------------
// mxv_mac_feeder : drives a streaming MAC through an M x K matrix-vector
// product, one operand pair per cycle, and emits one dot product per row.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          job start pulse (only looked at in IDLE)
//   bus (slave)    operand stream in, row-result stream out
//   mac_clr        one-cycle clear to the MAC accumulator at each row start
//   mac_g, mac_e   registered operands to the MAC (zero on idle cycles)
//   mac_o          MAC accumulator output
//   busy           high whenever the FSM is not IDLE
//   done           one-cycle pulse after the last row's result handshake
//
// Build macro: MXV_ROWIDX_EN adds bus.res_row (row index of the result).
// ---------------------------------------------------------------------------
module mxv_mac_feeder
  import mxv_pkg::*;
#(
  parameter int N       = 8,
  parameter int K       = 3,
  parameter int M       = 3,
  parameter int MAC_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  mxv_mac_feeder_if.slave               bus,
  output logic                          mac_clr,
  output logic signed [N-1:0]           mac_g,
  output logic signed [N-1:0]           mac_e,
  input  logic signed [res_w(N,K)-1:0]  mac_o,
  output logic                          busy,
  output logic                          done
);

  localparam int RW  = res_w(N, K);
  localparam int RIW = idx_w(M);
  localparam int KW  = idx_w(K);
  localparam int DW  = idx_w(MAC_LAT + 1);

  state_t               state, state_nx;
  logic [RIW-1:0]       r;
  logic [KW-1:0]        k;
  logic [DW-1:0]        d;
  logic                 in_ready_c;
  logic                 res_valid_q;
  logic signed [RW-1:0] res_data_q;

  logic in_hs, res_hs, last_k, last_r, d_zero;

  assign in_hs  = bus.in_valid && in_ready_c;
  assign res_hs = res_valid_q && bus.res_ready;
  assign last_k = (k == KW'(K - 1));
  assign last_r = (r == RIW'(M - 1));
  assign d_zero = (d == '0);

  assign bus.in_ready  = in_ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
`ifdef MXV_ROWIDX_EN
  assign bus.res_row   = res_valid_q ? r : '0;
`endif

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLR;
      CLR:     state_nx = FEED;
      FEED:    if (in_hs && last_k) state_nx = DRAIN;
      DRAIN:   if (d_zero) state_nx = HOLD;
      HOLD:    if (res_hs) state_nx = last_r ? IDLE : CLR;
      default: state_nx = IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    in_ready_c = 1'b0;
    mac_clr    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE:    busy       = 1'b0;
      CLR:     mac_clr    = 1'b1;
      FEED:    in_ready_c = 1'b1;
      default: ;
    endcase
  end

  // ---- counters, MAC operand registers, result capture ----
  // Operands default to zero every cycle so a stalled input stream feeds the
  // MAC a zero product instead of repeating the previous pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      k           <= '0;
      d           <= '0;
      mac_g       <= '0;
      mac_e       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done        <= 1'b0;
    end else begin
      mac_g <= '0;
      mac_e <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) r <= '0;
        end
        CLR: begin
          k <= '0;
        end
        FEED: begin
          if (in_hs) begin
            mac_g <= bus.in_g;
            mac_e <= bus.in_e;
            k     <= k + 1'b1;
            if (last_k) d <= DW'(MAC_LAT);
          end
        end
        DRAIN: begin
          // The last pair reaches mac_g one cycle after its handshake and
          // the accumulator MAC_LAT cycles later, so capture once d hits 0.
          if (d_zero) begin
            res_data_q  <= mac_o;
            res_valid_q <= 1'b1;
          end else begin
            d <= d - 1'b1;
          end
        end
        HOLD: begin
          if (res_hs) begin
            res_valid_q <= 1'b0;
            if (last_r) done <= 1'b1;
            else        r    <= r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_mac_feeder.sv
// ---------------------------------------------------------------------------
// tb_mxv_mac_feeder : scoreboard bench for mxv_mac_feeder (N=8, K=3, M=3,
// MAC_LAT=1) with a behavioural one-cycle MAC standing in for mac_nnbit_1cc.
// Build macro MXV_ROWIDX_EN additionally checks res_row.
// ---------------------------------------------------------------------------
module tb_mxv_mac_feeder;
  import mxv_pkg::*;

  localparam int N       = 8;
  localparam int K       = 3;
  localparam int M       = 3;
  localparam int MAC_LAT = 1;
  localparam int RW      = res_w(N, K);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mac_clr, busy, done;
  logic signed [N-1:0]   mac_g, mac_e;
  logic signed [RW-1:0]  mac_o;
  logic signed [RW-1:0]  acc;
  logic signed [2*N-1:0] prod;

  always #5 clk = ~clk;

  mxv_mac_feeder_if #(.N(N), .K(K)
`ifdef MXV_ROWIDX_EN
    , .M(M)
`endif
  ) bus ();

  mxv_mac_feeder #(.N(N), .K(K), .M(M), .MAC_LAT(MAC_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .mac_clr (mac_clr),
    .mac_g   (mac_g),
    .mac_e   (mac_e),
    .mac_o   (mac_o),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural MAC: mac_clr acts as its synchronous reset.
  assign prod = mac_g * mac_e;
  always_ff @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else         acc <= acc + RW'(prod);
  end
  assign mac_o = acc;

  typedef struct {
    longint data;
    int     row;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int stall_n = 0;
  int done_cnt = 0;
  int clr_cnt = 0;

  int G[M][K];
  int E[K];
  longint exp_rows[M];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // ---- monitor: drives res_ready, pops scoreboard on each handshake ----
  initial begin
    int   cnt;
    bit   held;
    exp_t ex;
    logic signed [RW-1:0] held_data;
    cnt = 0;
    held = 0;
    held_data = '0;
    bus.res_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
        cnt = 0;
        bus.res_ready = 1'b1;
        continue;
      end
      if (mac_clr) clr_cnt++;
      if (done) begin
        done_cnt++;
        chk("busy_with_done", busy, 0);
      end
      if (bus.res_valid) begin
        chk("in_ready_in_hold", bus.in_ready, 0);
        if (held) chk("res_data_stable", bus.res_data, held_data);
        if (cnt < stall_n) begin
          bus.res_ready = 1'b0;
          cnt++;
          held = 1;
          held_data = bus.res_data;
        end else begin
          bus.res_ready = 1'b1;
          if (q.size() == 0) begin
            chk("unexpected_result", bus.res_data, 0);
            if (bus.res_data == 0) begin
              errors++;
              $display("FAIL unexpected_result: got a result with empty scoreboard");
            end
          end else begin
            ex = q.pop_front();
            chk("res_data", bus.res_data, ex.data);
`ifdef MXV_ROWIDX_EN
            chk("res_row", bus.res_row, ex.row);
`endif
          end
          held = 0;
          cnt = 0;
        end
      end else begin
        bus.res_ready = (stall_n == 0);
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic push(input int g, input int e, input bit st);
    bit hs;
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_g = N'(g);
    bus.in_e = N'(e);
    start = st;
    forever begin
      hs = bus.in_ready;
      @(posedge clk);
      if (hs) break;
      t++;
      if (t > 100) begin
        chk("in_handshake_timeout", t, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n - 1) begin
        @(negedge clk);
        chk("bubble_mac_g", mac_g, 0);
        chk("bubble_mac_e", mac_e, 0);
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_mac_clr",   mac_clr,       0);
    chk("rst_mac_g",     mac_g,         0);
    chk("rst_mac_e",     mac_e,         0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data,  0);
    chk("rst_busy",      busy,          0);
    chk("rst_done",      done,          0);
`ifdef MXV_ROWIDX_EN
    chk("rst_res_row",   bus.res_row,   0);
`endif
  endtask

  task automatic run_job(input int gp, input int stl, input bit poke_start);
    int base_done, base_clr, t;
    base_done = done_cnt;
    base_clr = clr_cnt;
    stall_n = stl;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < M; r++) begin
      q.push_back('{exp_rows[r], r});
      for (int kk = 0; kk < K; kk++) begin
        push(G[r][kk], E[kk], poke_start && (r == 1));
        gap(gp);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b0;
    t = 0;
    while (done_cnt < base_done + 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("job_done", done_cnt - base_done, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - base_done, 1);
    chk("clr_pulses", clr_cnt - base_clr, M);
    chk("scoreboard_empty", q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_g = '0;
    bus.in_e = '0;
    G = '{'{29, 74, -39}, '{67, -71, 56}, '{75, -45, 34}};
    E = '{-38, -91, 47};
    exp_rows = '{-9669, 6547, 2843};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal, back-to-back, consumer always ready
    run_job(0, 0, 0);
    // two bubble cycles between every pair
    run_job(2, 0, 0);
    // consumer stalls 5 cycles on each result
    run_job(0, 5, 0);
    // start held high during row 1 while busy
    run_job(0, 0, 1);

    // reset during row-1 FEED, then a fresh job
    stall_n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q.push_back('{exp_rows[0], 0});
    for (int kk = 0; kk < K; kk++) push(G[0][kk], E[kk], 1'b0);
    push(G[1][0], E[0], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    chk("row0_before_reset", q.size(), 0);
    q.delete();
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    #2;
    rst_n = 1'b1;

    G = '{'{1, 1, 1}, '{67, -71, 56}, '{75, -45, 34}};
    E = '{2, 3, 4};
    exp_rows = '{9, 145, 151};
    run_job(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
